// File: rtl/alu_pkg.sv
// Purpose : shared ALU op codes and execute-unit FSM state type.
// Latency : n/a (declarations only).
// Backpressure: n/a. Op codes are shared with the ALU control decoder.
package alu_pkg;

   localparam logic [2:0] ALU_NOP  = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;
   localparam logic [2:0] ALU_MUL  = 3'b011;
   localparam logic [2:0] ALU_DIV  = 3'b100;
   localparam logic [2:0] ALU_AND  = 3'b101;
   localparam logic [2:0] ALU_OR   = 3'b110;
   localparam logic [2:0] ALU_NOP2 = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } alu_state_t;

endpackage

// File: rtl/alu_div_iter.sv
// Purpose : unsigned restoring divider, one quotient bit per cycle.
// Latency : WIDTH cycles after start_i; done_o marks the final step.
// Backpressure: none; caller must not pulse start_i while busy_o is high.
// Ports   : clk, rst_n, start_i (load operands), dividend_i/divisor_i (magnitudes),
//           busy_o (iterating), done_o (this edge completes), quotient_o (valid with done_o).
module alu_div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic [WIDTH:0]   rem_sh;
   logic             ge;

   // quo_q starts as the dividend; its MSB feeds the partial remainder while
   // quotient bits fill in from the LSB.
   assign rem_sh = {rem_q, quo_q[WIDTH-1]};
   assign ge     = (rem_sh >= {1'b0, dvs_q});
   // The true difference is below the divisor, so the low WIDTH bits are exact.
   assign rem_d  = ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
   assign quo_d  = {quo_q[WIDTH-2:0], ge};

   assign busy_o     = busy_q;
   assign done_o     = busy_q && (cnt_q == LAST);
   assign quotient_o = quo_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         cnt_q  <= '0;
         rem_q  <= '0;
         quo_q  <= dividend_i;
         dvs_q  <= divisor_i;
      end else if (busy_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == LAST) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Purpose : execute-stage ALU (ADD/SUB/AND/OR/NOP 1 cycle, iterative MUL, signed DIV).
// Latency : 1 cycle simple ops and DIV special cases; WIDTH+1 for MUL and DIV.
// Backpressure: result held while out_ready=0; in_ready = IDLE | (DONE & out_ready).
// Ports   : clk, rst_n; in_valid/in_ready, alu_op, op_a, op_b (request);
//           out_valid/out_ready, result, zero, div_by_zero (response).
// Build   : define ALU_FAST_MUL_EN for a single-cycle combinational multiply.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   alu_state_t       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             rdy_en_q;

   logic             accept;
   logic [WIDTH-1:0] quick_res;
   logic             quick_dbz, quick_done;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             div_start, div_busy, div_done;
   logic [WIDTH-1:0] div_quo, div_signed;

   // rdy_en_q keeps in_ready low while reset is held and for the release edge.
   assign in_ready  = rdy_en_q && !div_busy &&
                      ((state_q == IDLE) || ((state_q == DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign div_by_zero = dbz_q;

   assign a_mag = op_a[WIDTH-1] ? -op_a : op_a;
   assign b_mag = op_b[WIDTH-1] ? -op_b : op_b;
   assign div_start  = accept && (alu_op == ALU_DIV) && !quick_done;
   assign div_signed = neg_q ? -div_quo : div_quo;
   assign acc_step   = acc_q + (mplier_q[0] ? mcand_q : '0);

   // Ops that resolve at accept time go straight to DONE.
   always_comb begin
      quick_res  = '0;
      quick_dbz  = 1'b0;
      quick_done = 1'b1;
      case (alu_op)
         ALU_ADD: quick_res = op_a + op_b;
         ALU_SUB: quick_res = op_a - op_b;
         ALU_AND: quick_res = op_a & op_b;
         ALU_OR:  quick_res = op_a | op_b;
         ALU_MUL: begin
`ifdef ALU_FAST_MUL_EN
            quick_res = op_a * op_b;
`else
            quick_done = 1'b0;
`endif
         end
         ALU_DIV: begin
            if (op_b == '0) begin
               quick_res = '1;
               quick_dbz = 1'b1;
            end else if ((op_a == MIN_VAL) && (op_b == '1)) begin
               quick_res = MIN_VAL;
            end else begin
               quick_done = 1'b0;
            end
         end
         default: quick_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      dbz_d    = dbz_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;

      case (state_q)
         MUL: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d  = DONE;
               result_d = acc_step;
               zero_d   = (acc_step == '0);
               dbz_d    = 1'b0;
            end
         end
         DIV: begin
            if (div_done) begin
               state_d  = DONE;
               result_d = div_signed;
               zero_d   = (div_signed == '0);
               dbz_d    = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: ;
      endcase

      // Accepting in DONE overrides the return to IDLE above.
      if (accept) begin
         neg_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
         if (quick_done) begin
            state_d  = DONE;
            result_d = quick_res;
            zero_d   = (quick_res == '0);
            dbz_d    = quick_dbz;
         end else if (alu_op == ALU_MUL) begin
            state_d  = MUL;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
         end else begin
            state_d = DIV;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         dbz_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         dbz_q    <= dbz_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rdy_en_q <= 1'b1;
      end
   end

   alu_div_iter #(.WIDTH(WIDTH)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (a_mag),
      .divisor_i  (b_mag),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Purpose : scoreboard bench for alu_exec_unit (WIDTH=32), directed vectors.
// Latency : expected latency travels with each scoreboard entry.
// Backpressure: exercises out_ready stalls, back-to-back accept and reset mid-DIV.
module tb_alu_exec_unit;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = W + 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [2:0]   alu_op = 3'b000;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         zero;
   logic         div_by_zero;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         d;
      int           lat;
      int           acc;
   } exp_t;
   exp_t exp_q[$];

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_op      (alu_op),
      .op_a        (op_a),
      .op_b        (op_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%h expected 0x%h", name, got, want);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic z, input logic d, input int lat);
      exp_t e;
      int   waited;
      waited = 0;
      in_valid = 1'b1;
      alu_op   = op;
      op_a     = a;
      op_b     = b;
      #1;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!in_ready) begin
         n_chk++;
         $display("FAIL accept_timeout: in_ready stayed 0 for op %0d", op);
         in_valid = 1'b0;
         return;
      end
      e.res = res;
      e.z   = z;
      e.d   = d;
      e.lat = lat;
      e.acc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   // Monitor: samples just after each negedge once inputs have settled.
   initial begin
      int   first;
      bit   have;
      exp_t e;
      first = 0;
      have  = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            have = 1'b0;
         end else if (out_valid) begin
            if (exp_q.size() == 0) begin
               if (!have) begin
                  n_chk++;
                  $display("FAIL unexpected_output: got result 0x%h, expected no output", result);
               end
               have = !out_ready;
            end else begin
               if (!have) begin
                  have  = 1'b1;
                  first = cyc;
               end
               e = exp_q[0];
               if (!out_ready) begin
                  check("hold_result", result, e.res);
               end else begin
                  check("result", result, e.res);
                  check("zero", W'(zero), W'(e.z));
                  check("div_by_zero", W'(div_by_zero), W'(e.d));
                  check("latency", W'(first - e.acc + 1), W'(e.lat));
                  void'(exp_q.pop_front());
                  have = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      int t;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_in_ready", W'(in_ready), '0);
      check("rst_out_valid", W'(out_valid), '0);
      check("rst_result", result, '0);
      check("rst_zero", W'(zero), '0);
      check("rst_dbz", W'(div_by_zero), '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      out_ready = 1'b1;

      send(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1);
      wait_drain();

      // SUB then AND accepted on the cycle SUB's result is taken.
      send(ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1);
      send(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1);
      send(ALU_OR,  32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0, 1'b0, 1);
      wait_drain();

      // MUL with the consumer stalled for 5 cycles after the result appears.
      out_ready = 1'b0;
      send(ALU_MUL, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1'b0, MUL_LAT);
      t = 0;
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (5) @(negedge clk);
      out_ready = 1'b1;
      wait_drain();

      send(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0, W + 1);
      send(ALU_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
      send(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1);
      send(ALU_DIV, 32'd100, 32'hFFFF_FFFD, 32'hFFFF_FFDF, 1'b0, 1'b0, W + 1);
      wait_drain();

      // Reset ten cycles into a DIV: the divide must vanish without output.
      send(ALU_DIV, 32'd100, 32'd3, 32'd33, 1'b0, 1'b0, W + 1);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      #2;
      check("midrst_in_ready", W'(in_ready), '0);
      check("midrst_out_valid", W'(out_valid), '0);
      check("midrst_result", result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #2;
      check("postrst_in_ready", W'(in_ready), W'(1));
      check("postrst_out_valid", W'(out_valid), '0);
      @(negedge clk);

      send(ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);
      send(ALU_NOP2, 32'd9, 32'd3, 32'h0, 1'b1, 1'b0, 1);
      send(ALU_NOP, 32'd5, 32'd6, 32'h0, 1'b1, 1'b0, 1);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
